// File: rtl/shift_word_serializer_pkg.sv
`default_nettype none
// =============================================================================
// Module   : shift_pkg
// Brief    : Shared state encoding and shift-direction constants for the
//            word serializer and its downstream bidirectional shift register.
// Revision : 1.0
// =============================================================================
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ser_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_word_serializer.sv
`default_nettype none
// =============================================================================
// Module   : shift_word_serializer
// Brief    : Serializes handshaked parallel words one bit per clock, ordered so
//            the downstream shift register holds the word after WIDTH shifts.
// Revision : 1.0
// =============================================================================
module shift_word_serializer
   import shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   output logic             d_in,
   output logic             right,
   output logic             bit_valid,
   output logic             word_done
);

   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_buf;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir;
   logic             w_accept;
   logic             w_last;

   // rst is active-low; gating keeps in_ready low for the whole reset window
   assign in_ready = rst && ((r_state == IDLE) || (r_state == DONE));
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      bit_valid   = 1'b0;
      word_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            bit_valid = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            word_done = 1'b1;
            if (w_accept) begin
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Right shifts send the LSB first, left shifts the MSB first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf <= '0;
         r_cnt <= '0;
         r_dir <= DIR_LEFT;
      end else if (w_accept) begin
         r_buf <= in_data;
         r_dir <= in_dir;
         r_cnt <= '0;
      end else if (r_state == SHIFT) begin
         r_buf <= (r_dir == DIR_RIGHT) ? (r_buf >> 1) : (r_buf << 1);
         r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
      end
   end

   assign d_in  = bit_valid && ((r_dir == DIR_RIGHT) ? r_buf[0] : r_buf[WIDTH-1]);
   assign right = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_shift_word_serializer.sv
`default_nettype none
// =============================================================================
// Module   : tb_shift_word_serializer
// Brief    : Self-checking bench with a transaction-level output model and a
//            downstream shift-register model for the word serializer.
// Revision : 1.0
// =============================================================================
module tb_shift_word_serializer;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_dir;
   logic         d_in;
   logic         right;
   logic         bit_valid;
   logic         word_done;

   int n_vec  = 0;
   int n_fail = 0;

   // model state: cycles since acceptance (0 = no word in flight)
   int           t     = 0;
   logic [W-1:0] mword = '0;
   logic         mdir  = 1'b0;
   logic [W-1:0] ds    = '0;
   int           cyc   = 0;
   int           n_done = 0;
   int           done_last = 0;
   int           done_prev = 0;

   shift_word_serializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dir    (in_dir),
      .d_in      (d_in),
      .right     (right),
      .bit_valid (bit_valid),
      .word_done (word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Compare process: check every cycle, then advance the model across the edge
   always @(negedge clk) begin
      logic e_ready, e_bv, e_din, e_done;
      cyc++;
      if (!rst) begin
         chk("rst_ready", in_ready, 0);
         chk("rst_bv", bit_valid, 0);
         chk("rst_din", d_in, 0);
         chk("rst_right", right, 0);
         chk("rst_done", word_done, 0);
         t    = 0;
         mdir = 1'b0;
      end else begin
         e_ready = (t == 0) || (t == W + 1);
         e_bv    = (t >= 1) && (t <= W);
         e_din   = e_bv ? (mdir ? mword[t-1] : mword[W-t]) : 1'b0;
         e_done  = (t == W + 1);
         chk("in_ready", in_ready, e_ready);
         chk("bit_valid", bit_valid, e_bv);
         chk("d_in", d_in, e_din);
         chk("right", right, mdir);
         chk("word_done", word_done, e_done);
         if (e_done) chk("downstream", ds, mword);
         if (in_valid && e_ready) begin
            t     = 1;
            mword = in_data;
            mdir  = in_dir;
         end else if (t >= 1 && t <= W) begin
            t++;
         end else begin
            t = 0;
         end
      end
      if (word_done) begin
         n_done++;
         done_prev = done_last;
         done_last = cyc;
      end
      ds = right ? {d_in, ds[W-1:1]} : {ds[W-2:0], d_in};
   end

   task automatic directed(input logic [W-1:0] word, input logic dir, input logic [W-1:0] seq);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = word; in_dir = dir;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         chk("lit_bit", d_in, seq[W-1-k]);
         chk("lit_dir", right, dir);
      end
      @(negedge clk);
      chk("lit_done", word_done, 1);
   endtask

   initial begin
      int waited;
      bit found;
      int done_before;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
      #7;
      chk("lit_rst_ready", in_ready, 0);
      @(posedge clk); @(posedge clk); #3 rst = 1'b1;
      @(negedge clk);
      chk("lit_ready_after_rst", in_ready, 1);

      directed(4'b1011, 1'b1, 4'b1101);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("lit_idle_right", right, 1);
         chk("lit_idle_bv", bit_valid, 0);
         chk("lit_idle_din", d_in, 0);
      end

      directed(4'b1100, 1'b0, 4'b1100);

      // back-to-back: second word is held through SHIFT and taken in DONE
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 4'hA; in_dir = 1'b1;
      @(posedge clk); #1;
      in_data = 4'h5; in_dir = 1'b0;
      waited = 0; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         waited++;
         if (in_ready) found = 1'b1;
      end
      chk("b2b_ready_wait", waited, W + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (W + 2) @(negedge clk);
      chk("b2b_done_spacing", done_last - done_prev, W + 1);

      // random traffic, inputs change freely even while not ready
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = W'($urandom);
         in_dir   = 1'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2 * W + 4) @(posedge clk);

      // asynchronous reset during the third shift cycle
      #1;
      in_valid = 1'b1; in_data = 4'b0110; in_dir = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk);
      done_before = n_done;
      #2 rst = 1'b0;
      #1;
      chk("lit_abort_bv", bit_valid, 0);
      chk("lit_abort_din", d_in, 0);
      chk("lit_abort_right", right, 0);
      chk("lit_abort_ready", in_ready, 0);
      chk("lit_abort_done", word_done, 0);
      @(posedge clk); @(posedge clk); #3 rst = 1'b1;
      @(negedge clk);
      chk("lit_abort_ready_back", in_ready, 1);
      repeat (W + 3) @(negedge clk);
      chk("lit_abort_no_done", n_done, done_before);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
